fifo_frame_packer: RTL and testbench
====================================

# fifo_frame_packer

Downstream consumer of the 16×32 synchronous FIFO. Pops 32-bit words one at a time through the FIFO's read port. Groups every FRAME_LEN words into a frame and forwards them on a valid/ready stream. After the last data word of each frame it appends a 32-bit modulo-2^32 sum checksum word flagged with `out_last`.

## Interface
- FRAME_LEN, 4, data words per frame; legal range 1..255
- CNT_W, 8, width of `frame_count`
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset; asserted when 0
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO read request; one cycle per word
- fifo_data  input  32  FIFO read data; registered in the FIFO on the clock edge that samples `fifo_rd_en`=1 with the FIFO not empty
- out_data  output  32  stream data: a data word, or the checksum when `out_last`=1
- out_valid  output  1  `out_data`/`out_last` valid
- out_ready  input  1  downstream accepts on a clock edge where `out_valid` & `out_ready`
- out_last  output  1  marks the checksum word that closes a frame
- frame_count  output  CNT_W  completed frames; wraps modulo 2^CNT_W
- busy  output  1  high whenever state ≠ FETCH or `word_cnt` ≠ 0

## Operation
- Single clock domain.
- Internal state: `word_cnt` (8 bits), `csum` (32 bits), output holding register.
- States:
  - FETCH: `fifo_rd_en` = !fifo_empty (combinational). If !fifo_empty → WAIT, else stay.
  - WAIT: capture `fifo_data` into `out_data`, set `out_valid`=1, `out_last`=0 → SEND.
  - SEND: hold `out_data`/`out_valid`, stable, until handshake. On handshake:
    - `csum` += `out_data`, modulo 2^32 (carry discarded).
    - If `word_cnt` == FRAME_LEN-1: load `out_data` = updated `csum`, set `out_last`=1, keep `out_valid`=1 → CSUM.
    - Otherwise: `word_cnt`++, drop `out_valid` → FETCH.
  - CSUM: hold the checksum word until handshake. On handshake:
    - `out_valid`, `out_last` ← 0.
    - `csum`, `word_cnt` ← 0.
    - `frame_count`++.
    - → FETCH.
- At most one FIFO read is outstanding. `fifo_rd_en` is never asserted outside FETCH, and never while `fifo_empty`=1.
- No data word is dropped or duplicated. The FIFO word order is preserved on the stream.
- FRAME_LEN=1: each frame is one data word followed by a checksum equal to that word.
- `out_ready` is ignored while `out_valid`=0.
- Reset (`rst`=0, any time, including mid-frame or mid-handshake):
  - State → FETCH.
  - `out_valid`, `out_last`, `out_data`, `word_cnt`, `csum`, `frame_count`, `busy` → 0.
  - `fifo_rd_en` = 0 while in reset.
  - A partial frame is discarded. Words already popped are lost; the FIFO is reset by the same system reset.

## Timing
- All outputs except `fifo_rd_en` are registered. `fifo_rd_en` is a combinational function of state and `fifo_empty`.
- Per data word:
  - Cycle N: FETCH with `fifo_rd_en`=1.
  - Edge ending N: FIFO updates `fifo_data`; state → WAIT.
  - Cycle N+2: `out_valid`=1.
  - Cycle N+3 at earliest: next `fifo_rd_en`, provided `out_ready` was high in cycle N+2.
- Peak rate with `out_ready` tied high: one data word per 3 cycles. Each frame adds one checksum cycle.
- The checksum word follows the last data word with no idle cycle: `out_valid` stays high across the transition.
- Backpressure: `out_valid` is never withdrawn before a handshake. `out_data` and `out_last` are stable while `out_valid` & !`out_ready`.
- `fifo_empty` rising while in WAIT/SEND/CSUM has no effect. It is only sampled in FETCH.

## Test plan
- Basic frame (FRAME_LEN=4): push 0x1, 0x2, 0x3, 0x4, `out_ready`=1 → stream 0x1, 0x2, 0x3, 0x4, then 0xA with `out_last`=1; `frame_count`=1; exactly 4 `fifo_rd_en` pulses.
- Checksum wrap: frame 0xFFFFFFFF, 0x2, 0x0, 0x0 → checksum 0x00000001.
- Backpressure: hold `out_ready`=0 for 5 cycles on the 2nd word and on the checksum → values held stable, no `fifo_rd_en` during the stall, sequence and checksum unchanged.
- Starvation: push 2 words, wait 20 cycles, push 2 more → `fifo_rd_en` stays 0 while `fifo_empty`; frame completes with the correct checksum; `busy`=1 throughout the gap.
- Reset mid-frame: drop `rst` after 2 words are accepted → all outputs 0 next cycle. A following 4-word frame 0x10..0x13 yields checksum 0x46, `frame_count`=1.
- Counter wrap (CNT_W=2, FRAME_LEN=1): send 5 frames → `frame_count` reads 1, 2, 3, 0, 1; each checksum equals its data word.

Source files
------------

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: pops 32-bit words from a synchronous FIFO one at a time and
// forwards them on a valid/ready stream. Every FRAME_LEN data words are followed
// by a modulo-2^32 sum checksum word flagged with out_last.
module fifo_frame_packer #(
    parameter int FRAME_LEN = 4,    // data words per frame, 1..255
    parameter int CNT_W     = 8     // width of frame_count
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_data,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
);

    // FETCH: request a word. WAIT: FIFO read data lands. SEND: offer a data word.
    // CSUM: offer the checksum word that closes the frame.
    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_CSUM
    } state_t;

    localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [7:0]       CNT_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] FC_ONE   = CNT_W'(1);

    state_t             state, state_nx;
    logic [7:0]         word_cnt, word_cnt_nx;
    logic [31:0]        csum, csum_nx;
    logic [31:0]        sum;
    logic [31:0]        out_data_nx;
    logic               out_valid_nx;
    logic               out_last_nx;
    logic [CNT_W-1:0]   frame_count_nx;
    logic               busy_nx;

    // Next-state, datapath update and the combinational FIFO read request.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_nx       = state;
        word_cnt_nx    = word_cnt;
        csum_nx        = csum;
        out_data_nx    = out_data;
        out_valid_nx   = out_valid;
        out_last_nx    = out_last;
        frame_count_nx = frame_count;
        fifo_rd_en     = 1'b0;
        sum            = csum + out_data;

        case (state)
            S_FETCH: begin
                // Reset gating keeps the request low while the system is in reset.
                fifo_rd_en = !fifo_empty && rst;
                if (!fifo_empty) begin
                    state_nx = S_WAIT;
                end
            end

            S_WAIT: begin
                // The FIFO registered the word on the edge that ended FETCH.
                out_data_nx  = fifo_data;
                out_valid_nx = 1'b1;
                out_last_nx  = 1'b0;
                state_nx     = S_SEND;
            end

            S_SEND: begin
                if (out_ready) begin
                    csum_nx = sum;
                    if (word_cnt == LAST_IDX) begin
                        // Checksum follows directly; out_valid stays high.
                        out_data_nx = sum;
                        out_last_nx = 1'b1;
                        state_nx    = S_CSUM;
                    end else begin
                        word_cnt_nx  = word_cnt + CNT_ONE;
                        out_valid_nx = 1'b0;
                        state_nx     = S_FETCH;
                    end
                end
            end

            S_CSUM: begin
                if (out_ready) begin
                    out_valid_nx   = 1'b0;
                    out_last_nx    = 1'b0;
                    csum_nx        = '0;
                    word_cnt_nx    = '0;
                    frame_count_nx = frame_count + FC_ONE;
                    state_nx       = S_FETCH;
                end
            end

            default: begin
                state_nx = S_FETCH;
            end
        endcase

        // Registered busy reflects the state/word count it is registered alongside.
        busy_nx = (state_nx != S_FETCH) || (word_cnt_nx != 8'd0);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            word_cnt    <= '0;
            csum        <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state       <= state_nx;
            word_cnt    <= word_cnt_nx;
            csum        <= csum_nx;
            out_data    <= out_data_nx;
            out_valid   <= out_valid_nx;
            out_last    <= out_last_nx;
            frame_count <= frame_count_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Bench for fifo_frame_packer: two instances (FRAME_LEN=4/CNT_W=8 and
// FRAME_LEN=1/CNT_W=2) share one FIFO model, one scoreboard and one monitor;
// `sel` picks which instance is active.
module tb_fifo_frame_packer;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel = 1'b0;
    logic        out_ready;
    int          rdy_mode = 0;      // 0: ready high, 1: random, 2: ready low

    // FIFO model
    logic [31:0] mem [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_pulses = 0;
    logic [31:0] fifo_data;
    logic        fifo_empty;

    // Instance signals
    logic        empty_a, rd_a, valid_a, last_a, busy_a, ready_a;
    logic [31:0] data_a;
    logic [7:0]  fc_a;
    logic        empty_b, rd_b, valid_b, last_b, busy_b, ready_b;
    logic [31:0] data_b;
    logic [1:0]  fc_b;

    // Muxed view of the active instance
    logic        m_rd, m_valid, m_last, m_busy;
    logic [31:0] m_data;
    logic [7:0]  m_fc;

    // Scoreboard and reference model state
    beat_t       exp_q [$];
    logic [31:0] m_sum = '0;
    int          m_n = 0;
    int          frame_len = 4;
    int          acc_cnt = 0;
    logic [7:0]  exp_fc = '0;
    logic [7:0]  fc_mask = 8'hFF;
    logic        fc_pending = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    int          n_total = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign empty_a    = fifo_empty | sel;
    assign empty_b    = fifo_empty | !sel;
    assign ready_a    = out_ready & !sel;
    assign ready_b    = out_ready & sel;
    assign m_rd       = sel ? rd_b    : rd_a;
    assign m_valid    = sel ? valid_b : valid_a;
    assign m_last     = sel ? last_b  : last_a;
    assign m_busy     = sel ? busy_b  : busy_a;
    assign m_data     = sel ? data_b  : data_a;
    assign m_fc       = sel ? {6'b0, fc_b} : fc_a;

    fifo_frame_packer #(.FRAME_LEN(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_rd_en(rd_a),
        .fifo_data(fifo_data), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready_a), .out_last(last_a), .frame_count(fc_a), .busy(busy_a)
    );

    fifo_frame_packer #(.FRAME_LEN(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_rd_en(rd_b),
        .fifo_data(fifo_data), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .out_last(last_b), .frame_count(fc_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // FIFO read port: data is registered on the edge that samples a read request.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= wr_ptr;
            fifo_data <= '0;
        end else if (m_rd) begin
            fifo_data <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_pulses <= rd_pulses + 1;
        end
    end

    // Downstream ready generator.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: protocol checks and scoreboard comparison at the falling edge.
    always @(negedge clk) begin
        beat_t exp_b;
        if (!rst) begin
            exp_q.delete();
            acc_cnt    = 0;
            exp_fc     = '0;
            fc_pending = 1'b0;
            prev_rd    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("busy", {31'b0, m_busy}, {31'b0, m_valid | prev_rd | (acc_cnt != 0)});
            if (m_rd) begin
                check("rd_legal(empty,valid,prev_rd)", {29'b0, fifo_empty, m_valid, prev_rd}, 32'd0);
            end
            if (prev_stall) begin
                check("hold_valid", {31'b0, m_valid}, 32'd1);
                check("hold_data", m_data, prev_data);
                check("hold_last", {31'b0, m_last}, {31'b0, prev_last});
            end
            if (fc_pending) begin
                check("frame_count", {24'b0, m_fc}, {24'b0, exp_fc});
                fc_pending = 1'b0;
            end
            if (m_valid && out_ready) begin
                check("beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("data", m_data, exp_b.data);
                    check("last", {31'b0, m_last}, {31'b0, exp_b.last});
                    if (exp_b.last) begin
                        exp_fc     = (exp_fc + 8'd1) & fc_mask;
                        fc_pending = 1'b1;
                        acc_cnt    = 0;
                    end else begin
                        acc_cnt++;
                    end
                end
            end
            prev_stall = m_valid && !out_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_rd    = m_rd;
        end
    end

    // Write one word into the FIFO and extend the expected stream: data words in
    // order, and after every frame_len words their wrapped sum flagged last.
    task automatic push_word(input logic [31:0] w);
        beat_t b;
        mem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 1;
        b.data = w;
        b.last = 1'b0;
        exp_q.push_back(b);
        m_sum = m_sum + w;
        m_n++;
        if (m_n == frame_len) begin
            b.data = m_sum;
            b.last = 1'b1;
            exp_q.push_back(b);
            m_sum = '0;
            m_n   = 0;
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_sum = '0;
        m_n   = 0;
        @(negedge clk);
        check("rst_valid", {31'b0, m_valid}, 32'd0);
        check("rst_last", {31'b0, m_last}, 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_frame_count", {24'b0, m_fc}, 32'd0);
        check("rst_busy", {31'b0, m_busy}, 32'd0);
        check("rst_rd_en", {31'b0, m_rd}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int p0;
        int t;
        int fc_tab [5];
        fc_tab = '{1, 2, 3, 0, 1};

        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_valid", {31'b0, m_valid}, 32'd0);
        check("init_busy", {31'b0, m_busy}, 32'd0);
        check("init_frame_count", {24'b0, m_fc}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Basic frame with ready held high.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        p0 = rd_pulses;
        for (int i = 1; i <= 4; i++) push_word(32'(i));
        drain("basic_drain");
        check("basic_rd_pulses", 32'(rd_pulses - p0), 32'd4);
        check("basic_frame_count", {24'b0, m_fc}, 32'd1);

        // Checksum wrap.
        push_word(32'hFFFF_FFFF);
        push_word(32'h2);
        push_word(32'h0);
        push_word(32'h0);
        drain("wrap_drain");

        // Stall: the first word is held with ready low; only one read may issue.
        rdy_mode = 2;
        p0 = rd_pulses;
        for (int i = 0; i < 4; i++) push_word(32'h100 + 32'(i));
        repeat (8) @(posedge clk);
        #1;
        check("stall_rd_pulses", 32'(rd_pulses - p0), 32'd1);
        rdy_mode = 1;
        drain("stall_drain");

        // Starvation: two words, a 20-cycle gap, then the rest of the frame.
        rdy_mode = 0;
        push_word(32'hCAFE_0001);
        push_word(32'hCAFE_0002);
        t = 0;
        while (acc_cnt < 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("starve_two_accepted", 32'(acc_cnt), 32'd2);
        repeat (20) begin
            @(negedge clk);
            check("starve_rd_en", {31'b0, m_rd}, 32'd0);
            check("starve_busy", {31'b0, m_busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        push_word(32'hCAFE_0003);
        push_word(32'hCAFE_0004);
        drain("starve_drain");

        // Randomized frames with random backpressure and push gaps.
        rdy_mode = 1;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 4; i++) begin
                push_word($urandom);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        drain("random_drain");

        // Reset mid-frame after two words are accepted, then a clean frame.
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        t = 0;
        while (acc_cnt < 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("midrst_two_accepted", 32'(acc_cnt), 32'd2);
        apply_reset();
        for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(i));
        drain("midrst_drain");
        check("midrst_frame_count", {24'b0, m_fc}, 32'd1);

        // Single-word frames on the 2-bit counter instance.
        apply_reset();
        sel       = 1'b1;
        frame_len = 1;
        fc_mask   = 8'h03;
        rdy_mode  = 1;
        for (int f = 0; f < 5; f++) begin
            push_word($urandom);
            drain("len1_drain");
            check("len1_frame_count", {24'b0, m_fc}, 32'(fc_tab[f]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
